// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler
//   Shares one counter datapath between NUM_REQ requesters. Start requests are
//   arbitrated round-robin. The winner's terminal count is latched, and the
//   datapath is sequenced clear -> run -> done. A done interrupt is held until the
//   owner acknowledges it.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        in   per-requester start request (level)
//   stop_val   in   packed terminal counts, slice i = [i*CNT_W +: CNT_W]
//   ack        in   per-requester acknowledge of done (level)
//   cnt_done   in   datapath reached cnt_stop
//   cnt_clear  out  datapath synchronous clear (one cycle per job)
//   cnt_en     out  datapath count enable
//   cnt_stop   out  latched terminal count of the current job
//   grant      out  one-hot datapath owner, 0 when idle
//   irq_start  out  one-cycle start pulse to the owner
//   irq_done   out  done interrupt, held until ack
//   busy       out  high whenever not idle
module counter_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] stop_val,
    input  logic [NUM_REQ-1:0]       ack,
    input  logic                     cnt_done,
    output logic                     cnt_clear,
    output logic                     cnt_en,
    output logic [CNT_W-1:0]         cnt_stop,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       irq_start,
    output logic [NUM_REQ-1:0]       irq_done,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDoneWait
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gidx_q;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W:0]     probe;
    logic [CNT_W-1:0]   win_stop;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   ptr_next;

    // Round-robin search starting at ptr_q, wrapping at NUM_REQ.
    always_comb begin
        found      = 1'b0;
        winner     = '0;
        probe      = '0;
        win_stop   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            probe = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (probe >= (IDX_W+1)'(NUM_REQ)) begin
                probe = probe - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[probe[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = probe[IDX_W-1:0];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_stop      = stop_val[i*CNT_W +: CNT_W];
                win_onehot[i] = found;
            end
        end
    end

    assign ptr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant     <= '0;
            cnt_stop  <= '0;
            cnt_clear <= 1'b0;
            cnt_en    <= 1'b0;
            irq_start <= '0;
            irq_done  <= '0;
            busy      <= 1'b0;
        end else begin
            // Clear and start pulse live for the CLEAR cycle only.
            cnt_clear <= 1'b0;
            irq_start <= '0;
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q   <= StClear;
                        gidx_q    <= winner;
                        grant     <= win_onehot;
                        cnt_stop  <= win_stop;
                        cnt_clear <= 1'b1;
                        irq_start <= win_onehot;
                        busy      <= 1'b1;
                    end
                end
                StClear: begin
                    // A zero terminal count completes without any enable cycle.
                    if (cnt_stop == '0) begin
                        state_q  <= StDoneWait;
                        irq_done <= grant;
                    end else begin
                        state_q <= StRun;
                        cnt_en  <= 1'b1;
                    end
                end
                StRun: begin
                    if (cnt_done) begin
                        state_q  <= StDoneWait;
                        cnt_en   <= 1'b0;
                        irq_done <= grant;
                    end
                end
                StDoneWait: begin
                    if (ack[gidx_q]) begin
                        state_q  <= StIdle;
                        irq_done <= '0;
                        grant    <= '0;
                        ptr_q    <= ptr_next;
                        busy     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
module tb_counter_rr_scheduler;

    localparam int NR = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*CW-1:0] stop_val = '0;
    logic [NR-1:0]    ack = '0;
    logic             cnt_done;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CW-1:0]    cnt_stop;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    irq_start;
    logic [NR-1:0]    irq_done;
    logic             busy;

    counter_rr_scheduler #(
        .NUM_REQ(NR),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .stop_val (stop_val),
        .ack      (ack),
        .cnt_done (cnt_done),
        .cnt_clear(cnt_clear),
        .cnt_en   (cnt_en),
        .cnt_stop (cnt_stop),
        .grant    (grant),
        .irq_start(irq_start),
        .irq_done (irq_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared counter datapath.
    logic [CW-1:0] dp = '0;
    always @(posedge clk) begin
        if (cnt_clear) dp <= '0;
        else if (cnt_en) dp <= dp + 1'b1;
    end
    assign cnt_done = (dp == cnt_stop);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            idx;
        logic [CW-1:0] stop;
        int            en;
    } exp_t;

    exp_t sb[$];

    // Scoreboard monitor: pops one expectation per start pulse and checks the
    // latched count and the number of enable cycles when done rises.
    exp_t          cur;
    int            en_cnt  = 0;
    logic [NR-1:0] done_prev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt    = 0;
            done_prev = '0;
        end else begin
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("done_onehot0", $onehot0(irq_done), 1);
            if (irq_start != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: start %0h with no expectation", irq_start);
                end else begin
                    cur = sb.pop_front();
                    chk("start_vec", irq_start, 64'(1) << cur.idx);
                    chk("start_grant", grant, 64'(1) << cur.idx);
                    chk("start_stop", cnt_stop, cur.stop);
                    chk("start_clear", cnt_clear, 1);
                end
                en_cnt = 0;
            end
            if (cnt_en) en_cnt++;
            if (irq_done != '0 && done_prev == '0) begin
                chk("done_vec", irq_done, 64'(1) << cur.idx);
                chk("en_cycles", en_cnt, cur.en);
            end
            done_prev = irq_done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (irq_done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (irq_done == '0) begin
            checks++;
            failures++;
            $display("FAIL %s: irq_done timeout got 0 expected nonzero", name);
        end
    endtask

    // One job: request, check one-cycle grant latency, corrupt stop_val after the
    // grant edge, then acknowledge after ack_dly cycles.
    task automatic run_job(input logic [NR-1:0] r, input int idx, input logic [CW-1:0] stop,
                           input int ack_dly);
        stop_val[idx*CW +: CW] = stop;
        sb.push_back('{idx: idx, stop: stop, en: (stop == 0) ? 0 : int'(stop) + 1});
        req = r;
        @(negedge clk);
        chk("grant_latency", grant, 64'(1) << idx);
        chk("busy_on_grant", busy, 1);
        stop_val[idx*CW +: CW] = ~stop;
        wait_done("job_done");
        req = '0;
        repeat (ack_dly) @(negedge clk);
        chk("done_held", irq_done, 64'(1) << idx);
        ack = NR'(1) << idx;
        @(negedge clk);
        ack = '0;
        chk("idle_after_ack", {busy, grant, irq_done}, 0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [NR-1:0] r;
        int            idx;
        logic [CW-1:0] stop;
        int            ack_dly;
    } row_t;

    row_t rows[10];

    initial begin
        rows[0] = '{r: 4'b0001, idx: 0, stop: 16'd5, ack_dly: 3};
        rows[1] = '{r: 4'b1111, idx: 1, stop: 16'd3, ack_dly: 0};
        rows[2] = '{r: 4'b1111, idx: 2, stop: 16'd7, ack_dly: 0};
        rows[3] = '{r: 4'b1111, idx: 3, stop: 16'd2, ack_dly: 0};
        rows[4] = '{r: 4'b1111, idx: 0, stop: 16'd4, ack_dly: 0};
        rows[5] = '{r: 4'b1000, idx: 3, stop: 16'd6, ack_dly: 1};
        rows[6] = '{r: 4'b1001, idx: 0, stop: 16'd1, ack_dly: 0};
        rows[7] = '{r: 4'b1001, idx: 3, stop: 16'd9, ack_dly: 0};
        rows[8] = '{r: 4'b0100, idx: 2, stop: 16'd0, ack_dly: 0};
        rows[9] = '{r: 4'b0011, idx: 0, stop: 16'd3, ack_dly: 2};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {cnt_clear, cnt_en, cnt_stop, grant, irq_start, irq_done, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {busy, grant}, 0);

        for (int i = 0; i < 10; i++) begin
            run_job(rows[i].r, rows[i].idx, rows[i].stop, rows[i].ack_dly);
        end

        // Early req drop and wrong-index acks on channel 1.
        stop_val[1*CW +: CW] = 16'd6;
        sb.push_back('{idx: 1, stop: 16'd6, en: 7});
        req = 4'b0010;
        @(negedge clk);
        chk("ch1_grant", grant, 4'b0010);
        repeat (2) @(negedge clk);
        req = '0;
        ack = 4'b0001;
        repeat (3) @(negedge clk);
        chk("run_ignores_drop", {cnt_en, grant}, {1'b1, 4'b0010});
        ack = '0;
        wait_done("ch1_done");
        ack = 4'b1000;
        repeat (3) @(negedge clk);
        chk("wrong_ack_ignored", {busy, irq_done}, {1'b1, 4'b0010});
        ack = 4'b0010;
        @(negedge clk);
        ack = '0;
        chk("ch1_released", {busy, grant, irq_done}, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        stop_val[2*CW +: CW] = 16'd10;
        sb.push_back('{idx: 2, stop: 16'd10, en: 11});
        req = 4'b0100;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pre_reset_run", {cnt_en, grant}, {1'b1, 4'b0100});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {cnt_clear, cnt_en, cnt_stop, grant, irq_start, irq_done, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4'b0100, 2, 16'd2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_rr_scheduler.md
Name: counter_rr_scheduler

Overview:
- Controller that shares one counter datapath (clear/enable/done interface) between NUM_REQ requesters.
- Arbitrates start requests round-robin, loads the winner's terminal count and sequences clear -> run -> done.
- Raises a per-requester start pulse and a done interrupt, held until that requester acknowledges.
- Sits between the AXI register slices (req/ack/stop values) and a single shared counter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 16, width of terminal count and of the shared counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester start request, level
- stop_val  in  NUM_REQ*CNT_W  terminal count; slice i = bits [i*CNT_W +: CNT_W]
- ack  in  NUM_REQ  per-requester acknowledge of done, level
- cnt_done  in  1  datapath flag: count reached cnt_stop
- cnt_clear  out  1  datapath synchronous clear
- cnt_en  out  1  datapath count enable
- cnt_stop  out  CNT_W  latched terminal count of current job
- grant  out  NUM_REQ  one-hot owner of datapath, 0 when idle
- irq_start  out  NUM_REQ  one-cycle pulse on job start
- irq_done  out  NUM_REQ  done interrupt, held until ack
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, grant=0, cnt_stop=0
  - cnt_clear=0, cnt_en=0, irq_start=0, irq_done=0, busy=0
- States: IDLE, CLEAR, RUN, DONE_WAIT. All outputs derive from registered state or registers only; no input-to-output combinational path.
- IDLE:
  - If any req bit is set, pick the first set bit searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - Next edge: grant=onehot(winner), cnt_stop=stop_val[winner], go CLEAR.
  - No req set: stay in IDLE.
- CLEAR (exactly 1 cycle):
  - cnt_clear=1 and irq_start[g]=1 this cycle only.
  - Next state is DONE_WAIT if cnt_stop==0, else RUN.
- RUN:
  - cnt_en=1 every cycle.
  - When cnt_done=1 is sampled, the next edge enters DONE_WAIT. cnt_en drops in that first DONE_WAIT cycle, so exactly one enable cycle follows the datapath reaching stop.
  - req[g] deasserting during RUN is ignored; the job always completes.
- DONE_WAIT:
  - irq_done[g]=1, registered, set on the entry edge.
  - On the first cycle ack[g]=1 is sampled: clear irq_done[g], grant=0, ptr=(g+1) mod NUM_REQ, go IDLE.
  - ack on any non-granted index is ignored in every state.
  - ack[g] already high on entry is accepted on the first DONE_WAIT cycle, giving a minimum 1-cycle irq_done.
- Latency for an uncontended start:
  - req high at edge N -> grant and CLEAR at N+1 -> RUN at N+2.
  - cnt_done seen at edge M -> irq_done at M+1.
  - ack seen at edge K -> IDLE at K+1.
  - A new job can be granted at K+2.
- Simultaneous events:
  - Several req bits in IDLE resolve by the round-robin rule above.
  - cnt_done outside RUN is ignored.
  - stop_val changes after the grant edge do not affect cnt_stop.
- Reset mid-operation: every output returns to its reset value immediately (async); pending irq_done is lost and ptr returns to 0.
- At most one grant bit and at most one irq_start bit are ever high. irq_done has at most one bit high.

Test Plan:
- Single job: stop_val[0]=5, pulse req[0].
  - Expect irq_start[0] one cycle with cnt_clear, cnt_en high until the cycle after cnt_done, then irq_done[0].
  - Ack 3 cycles later -> IDLE, busy=0.
- Contention: req=4'b1111 held, ack each done immediately.
  - Grant order 0,1,2,3,0, each with its own stop_val latched into cnt_stop.
- Pointer wrap: after a job on channel 3, req=4'b1001 -> grant 0. After a job on channel 0, req=4'b1001 -> grant 3.
- Zero stop: stop_val[2]=0, req[2] -> CLEAR then DONE_WAIT directly; cnt_en never asserts; irq_done[2] set.
- Wrong ack and early drop:
  - In RUN for channel 1, drop req[1] and assert ack[0] -> no state change.
  - In DONE_WAIT, ack[3] -> irq_done[1] stays high until ack[1].
- Reset mid-RUN: assert rst_n=0 asynchronously between edges.
  - All outputs are 0 before the next edge.
  - After release with req[2] high, grant=4'b0100 and ptr restarts the search from 0.
